dma_arbiter_n: RTL and testbench

//  N-channel DMA arbiter. Sits between the channel register banks and the single DMA engine.

---
 rtl/dma_arbiter_n_pkg.sv | 13 +
 rtl/dma_rr_picker.sv | 30 +++
 rtl/dma_arbiter_n.sv | 149 ++++++++++++++
 tb/tb_dma_arbiter_n.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_arbiter_n_pkg.sv
// rtl/dma_arbiter_n_pkg.sv - shared widths, defaults and FSM encoding for the DMA arbiter
package dma_arbiter_n_pkg;

    localparam int NUM_DMA_CHANNELS = 8;
    localparam int DMA_PRIO_W       = 2;
    localparam int DMA_AGE_W        = 8;

    typedef enum logic {
        ARB_IDLE    = 1'b0,
        ARB_GRANTED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/dma_rr_picker.sv
// rtl/dma_rr_picker.sv - first set request bit at or after ptr, wrapping modulo N
module dma_rr_picker #(
    parameter int N    = 8,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic            valid,
    output logic [ID_W-1:0] idx
);

    always_comb begin
        int               c;
        logic [ID_W-1:0]  c_idx;
        valid = 1'b0;
        idx   = '0;
        c     = 0;
        c_idx = '0;
        for (int k = 0; k < N; k++) begin
            c = int'(ptr) + k;
            if (c >= N) c = c - N;
            c_idx = ID_W'(c);
            if (!valid && req[c_idx]) begin
                valid = 1'b1;
                idx   = c_idx;
            end
        end
    end

endmodule

// File: rtl/dma_arbiter_n.sv
// rtl/dma_arbiter_n.sv - N-channel DMA arbiter, priority + per-level round-robin; aging under DMA_ARB_AGING_EN
module dma_arbiter_n
    import dma_arbiter_n_pkg::*;
#(
    parameter int NUM_CH  = NUM_DMA_CHANNELS,
    parameter int PRIO_W  = DMA_PRIO_W,
    parameter int CH_ID_W = $clog2(NUM_CH)
`ifdef DMA_ARB_AGING_EN
    ,
    parameter int AGE_LIMIT = 15
`endif
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        ch_req,
    input  logic [NUM_CH-1:0]        ch_en,
    input  logic [NUM_CH*PRIO_W-1:0] ch_prio,
    input  logic                     engine_busy,
    input  logic                     engine_done,
    output logic [NUM_CH-1:0]        grant,
    output logic [CH_ID_W-1:0]       grant_id,
    output logic                     grant_valid
);

    localparam int NUM_LVL = 2 ** PRIO_W;

    arb_state_e          state, state_nxt;
    logic [NUM_CH-1:0]   eligible;
    logic [PRIO_W-1:0]   eprio     [NUM_CH];
    logic [NUM_CH-1:0]   lvl_req   [NUM_LVL];
    logic [NUM_LVL-1:0]  lvl_valid;
    logic [CH_ID_W-1:0]  lvl_idx   [NUM_LVL];
    logic [CH_ID_W-1:0]  rr_ptr    [NUM_LVL];
    logic [PRIO_W-1:0]   win_lvl, grant_lvl;
    logic [CH_ID_W-1:0]  win_id;
    logic                decide, done_ack;

    assign eligible    = ch_req & ch_en;
    assign grant_valid = |grant;

`ifdef DMA_ARB_AGING_EN
    logic [DMA_AGE_W-1:0] age [NUM_CH];
    logic [NUM_CH-1:0]    aged;
    logic                 aged_valid;
    logic [CH_ID_W-1:0]   aged_idx;

    always_comb begin
        aged = '0;
        for (int i = 0; i < NUM_CH; i++)
            aged[i] = eligible[i] && (age[i] == DMA_AGE_W'(AGE_LIMIT));
    end

    // Aged channels form a tier above every non-aged channel, sharing the top level's pointer.
    dma_rr_picker #(.N(NUM_CH), .ID_W(CH_ID_W)) u_aged_pick (
        .req   (aged),
        .ptr   (rr_ptr[NUM_LVL-1]),
        .valid (aged_valid),
        .idx   (aged_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) age[i] <= '0;
        end else if (decide) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!eligible[i] || (CH_ID_W'(i) == win_id))
                    age[i] <= '0;
                else if (age[i] != DMA_AGE_W'(AGE_LIMIT))
                    age[i] <= age[i] + DMA_AGE_W'(1);
            end
        end
    end
`endif

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            eprio[i] = ch_prio[i*PRIO_W +: PRIO_W];
`ifdef DMA_ARB_AGING_EN
            if (aged[i]) eprio[i] = '1;
`endif
        end
    end

    always_comb begin
        for (int l = 0; l < NUM_LVL; l++) begin
            lvl_req[l] = '0;
            for (int i = 0; i < NUM_CH; i++)
                lvl_req[l][i] = eligible[i] && (eprio[i] == PRIO_W'(l));
        end
    end

    for (genvar l = 0; l < NUM_LVL; l++) begin : g_lvl
        dma_rr_picker #(.N(NUM_CH), .ID_W(CH_ID_W)) u_pick (
            .req   (lvl_req[l]),
            .ptr   (rr_ptr[l]),
            .valid (lvl_valid[l]),
            .idx   (lvl_idx[l])
        );
    end

    always_comb begin
        win_lvl = '0;
        for (int l = 0; l < NUM_LVL; l++)
            if (lvl_valid[l]) win_lvl = PRIO_W'(l);
        win_id = lvl_idx[win_lvl];
`ifdef DMA_ARB_AGING_EN
        if (aged_valid) begin
            win_lvl = '1;
            win_id  = aged_idx;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ARB_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE:    if (!engine_busy && |eligible) state_nxt = ARB_GRANTED;
            ARB_GRANTED: if (engine_done)               state_nxt = ARB_IDLE;
            default:                                    state_nxt = ARB_IDLE;
        endcase
    end

    always_comb begin
        decide   = (state == ARB_IDLE) && !engine_busy && |eligible;
        done_ack = (state == ARB_GRANTED) && engine_done;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant     <= '0;
            grant_id  <= '0;
            grant_lvl <= '0;
            for (int l = 0; l < NUM_LVL; l++) rr_ptr[l] <= '0;
        end else if (decide) begin
            grant     <= NUM_CH'(1) << win_id;
            grant_id  <= win_id;
            grant_lvl <= win_lvl;
        end else if (done_ack) begin
            grant             <= '0;
            rr_ptr[grant_lvl] <= (grant_id == CH_ID_W'(NUM_CH-1)) ? '0 : grant_id + CH_ID_W'(1);
        end
    end

endmodule

// File: tb/tb_dma_arbiter_n.sv
// tb/tb_dma_arbiter_n.sv - scoreboard bench for dma_arbiter_n; aging expectations follow DMA_ARB_AGING_EN
module tb_dma_arbiter_n;

    localparam int NCH  = 8;
    localparam int PW   = 2;
    localparam int IDW  = 3;
    localparam int NLVL = 4;
    localparam int PV   = NCH * PW;
`ifdef DMA_ARB_AGING_EN
    localparam int AGE_LIM = 3;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [NCH-1:0] ch_req = '0;
    logic [NCH-1:0] ch_en = '0;
    logic [PV-1:0]  ch_prio = '0;
    logic           engine_busy = 1'b0;
    logic           engine_done = 1'b0;
    logic [NCH-1:0] grant;
    logic [IDW-1:0] grant_id;
    logic           grant_valid;

    int n_checks = 0;
    int n_errors = 0;
    bit mon_en = 1'b0;

    int m_ptr [NLVL];
    int m_age [NCH];
    bit m_granted = 1'b0;
    int m_w = 0;
    int m_lvl = 0;
    int exp_q [$];

    always #5 clk = ~clk;

    dma_arbiter_n #(
        .NUM_CH (NCH),
        .PRIO_W (PW)
`ifdef DMA_ARB_AGING_EN
        ,
        .AGE_LIMIT (AGE_LIM)
`endif
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ch_req      (ch_req),
        .ch_en       (ch_en),
        .ch_prio     (ch_prio),
        .engine_busy (engine_busy),
        .engine_done (engine_done),
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int prio_of(input int i);
        return int'(ch_prio[i*PW +: PW]);
    endfunction

    task automatic set_prio(input int ch, input int p);
        ch_prio[ch*PW +: PW] = PW'(p);
    endtask

    // Reference decision: highest level present (or the aged tier), first candidate from that level's pointer.
    task automatic model_decide();
        bit [NCH-1:0] e;
        bit [NCH-1:0] cand;
        bit           any_aged;
        int           top;
        int           w;
        int           c;
        e = ch_req & ch_en;
        cand = '0;
        any_aged = 1'b0;
        top = -1;
        w = -1;
`ifdef DMA_ARB_AGING_EN
        for (int i = 0; i < NCH; i++)
            if (e[i] && m_age[i] == AGE_LIM) begin
                cand[i] = 1'b1;
                any_aged = 1'b1;
            end
`endif
        if (any_aged) top = NLVL - 1;
        else begin
            for (int i = 0; i < NCH; i++) if (e[i] && prio_of(i) > top) top = prio_of(i);
            for (int i = 0; i < NCH; i++) if (e[i] && prio_of(i) == top) cand[i] = 1'b1;
        end
        for (int k = 0; k < NCH; k++) begin
            c = (m_ptr[top] + k) % NCH;
            if (w < 0 && cand[c]) w = c;
        end
`ifdef DMA_ARB_AGING_EN
        for (int i = 0; i < NCH; i++) begin
            if (!e[i] || i == w) m_age[i] = 0;
            else if (m_age[i] < AGE_LIM) m_age[i]++;
        end
`endif
        exp_q.push_back(w);
        m_granted = 1'b1;
        m_w = w;
        m_lvl = top;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                for (int l = 0; l < NLVL; l++) m_ptr[l] = 0;
                for (int i = 0; i < NCH; i++) m_age[i] = 0;
                m_granted = 1'b0;
                exp_q.delete();
            end else if (m_granted) begin
                if (engine_done) begin
                    m_ptr[m_lvl] = (m_w + 1) % NCH;
                    m_granted = 1'b0;
                end
            end else if (!engine_busy && (ch_req & ch_en) != '0) begin
                model_decide();
            end
        end
    end

    initial begin
        logic           pv;
        logic [NCH-1:0] pg;
        int             e;
        pv = 1'b0;
        pg = '0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("valid_vs_model", 64'(grant_valid), 64'(m_granted));
                chk("grant_onehot0", 64'($onehot0(grant)), 64'(1));
                chk("valid_eq_or", 64'(grant_valid), 64'(|grant));
                if (grant_valid && !pv) begin
                    if (exp_q.size() == 0) chk("sb_underflow", 64'(1), 64'(0));
                    else begin
                        e = exp_q.pop_front();
                        chk("sb_grant_id", 64'(grant_id), 64'(e));
                        chk("sb_grant_vec", 64'(grant), 64'(1) << e);
                    end
                end else if (grant_valid && pv) begin
                    chk("grant_hold", 64'(grant), 64'(pg));
                end
            end
            pv = grant_valid;
            pg = grant;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_done();
        engine_done = 1'b1;
        tick();
        engine_done = 1'b0;
    endtask

    task automatic wait_grant(input int budget, output int id);
        id = -1;
        for (int k = 0; k < budget; k++) begin
            if (grant_valid) begin
                id = int'(grant_id);
                break;
            end
            tick();
        end
    endtask

    task automatic apply_reset(input int cycles);
        mon_en = 1'b0;
        engine_done = 1'b0;
        engine_busy = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk("rst_async_clear", 64'(grant_valid), 64'(0));
        for (int k = 0; k < cycles; k++) begin
            tick();
            chk("rst_grant", 64'(grant), 64'(0));
            chk("rst_grant_id", 64'(grant_id), 64'(0));
            chk("rst_grant_valid", 64'(grant_valid), 64'(0));
        end
        rst_n = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic test_strict();
        ch_en = '1;
        ch_prio = '0;
        set_prio(0, 1);
        set_prio(5, 3);
        ch_req = 8'h21;
        tick();
        chk("t2_grant", 64'(grant), 64'(8'h20));
        chk("t2_grant_id", 64'(grant_id), 64'(5));
        tick();
        tick();
        ch_req = 8'h01;
        pulse_done();
        chk("t2_clear_on_done", 64'(grant), 64'(0));
        tick();
        chk("t2_regrant_ch0", 64'(grant), 64'(8'h01));
        chk("t2_regrant_id", 64'(grant_id), 64'(0));
        ch_req = '0;
        pulse_done();
    endtask

    task automatic test_rr();
        int order [4] = '{1, 3, 6, 1};
        int id;
        ch_prio = '0;
        set_prio(1, 2);
        set_prio(3, 2);
        set_prio(6, 2);
        ch_req = 8'h4A;
        for (int k = 0; k < 4; k++) begin
            wait_grant(5, id);
            chk("t3_rr_order", 64'(id), 64'(order[k]));
            pulse_done();
        end
        ch_req = '0;
        tick();
    endtask

    task automatic test_hold_bubble();
        int id;
        ch_req = 8'h10;
        wait_grant(5, id);
        chk("t4a_grant_id", 64'(id), 64'(4));
        ch_req = '0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t4a_hold", 64'(grant), 64'(8'h10));
        end
        pulse_done();
        chk("t4a_release", 64'(grant), 64'(0));
        pulse_done();
        chk("t4b_idle_done", 64'(grant_valid), 64'(0));
        engine_busy = 1'b1;
        ch_req = 8'h03;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t4c_busy_block", 64'(grant_valid), 64'(0));
        end
        engine_busy = 1'b0;
        tick();
        chk("t4c_grant_after_busy", 64'(grant_valid), 64'(1));
        ch_req = '0;
        pulse_done();
    endtask

    task automatic test_mask();
        int id;
        ch_en = 8'hFE;
        ch_prio = '0;
        set_prio(0, 3);
        set_prio(2, 0);
        ch_req = 8'h05;
        for (int k = 0; k < 3; k++) begin
            wait_grant(5, id);
            chk("t5_masked_grant", 64'(id), 64'(2));
            pulse_done();
        end
        ch_req = '0;
        ch_en = '1;
        tick();
    endtask

    task automatic test_aging();
        int id;
        int first7;
        int n_dec;
        first7 = 0;
`ifdef DMA_ARB_AGING_EN
        n_dec = 10;
`else
        n_dec = 100;
`endif
        ch_en = '1;
        ch_prio = '0;
        set_prio(0, 3);
        set_prio(1, 3);
        set_prio(7, 0);
        ch_req = 8'h83;
        for (int d = 1; d <= n_dec; d++) begin
            wait_grant(5, id);
            if (id < 0) chk("t6_grant_timeout", 64'(0), 64'(1));
            if (id == 7 && first7 == 0) first7 = d;
            pulse_done();
        end
`ifdef DMA_ARB_AGING_EN
        chk("t6_aged_decision", 64'(first7), 64'(4));
`else
        chk("t6_starved_decision", 64'(first7), 64'(0));
`endif
        ch_req = '0;
        tick();
    endtask

    task automatic run_random(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            if ($urandom_range(0, 5) == 0) begin
                ch_req  = NCH'($urandom);
                ch_prio = PV'($urandom);
                ch_en   = ($urandom_range(0, 3) == 0) ? NCH'($urandom) : '1;
            end
            engine_done = m_granted ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
            engine_busy = !m_granted && ($urandom_range(0, 5) == 0);
            tick();
        end
        engine_done = 1'b0;
        engine_busy = 1'b0;
    endtask

    initial begin
        int id;
        ch_req = '1;
        ch_en = '1;
        apply_reset(4);
        ch_req = '0;
        tick();
        test_strict();
        apply_reset(2);
        test_rr();
        test_hold_bubble();
        test_mask();
        apply_reset(2);
        test_aging();
        apply_reset(2);
        run_random(4000);
        ch_req = '1;
        ch_en = '1;
        wait_grant(8, id);
        chk("pre_reset_grant", 64'(grant_valid), 64'(1));
        tick();
        chk("sb_drained", 64'(exp_q.size()), 64'(0));
        apply_reset(2);
        ch_req = '0;
        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
